if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction Fetch stage of the 16-bit pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake that tolerates wait states.
- Delivers {pc, pc+2, instruction, valid} to IF/ID.
- Honours hazard-unit stalls and branch/jump redirects from later stages. A redirect flushes any in-flight or buffered fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, encoding driven on instr_o when no valid word is delivered (bubble).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- stall_i  input  1  hazard unit: hold outputs, do not advance delivery
- redirect_valid_i  input  1  taken branch/jump: load new PC, flush
- redirect_pc_i  input  16  redirect target
- imem_req_o  output  1  instruction memory request
- imem_addr_o  output  16  request address, bit0 always 0
- imem_ack_i  input  1  memory has data; may assert in the same cycle as req
- imem_rdata_i  input  16  instruction word, valid when ack=1
- pc_o  output  16  PC of the delivered instruction
- pc_plus2_o  output  16  pc_o+2, mod 2^16
- instr_o  output  16  delivered instruction, or NOP_INSTR
- instr_valid_o  output  1  instr_o is a real fetched word

Behaviour:
- Reset (async): pc_q=RESET_PC; state=FETCH; pc_o=0, pc_plus2_o=0, instr_o=NOP_INSTR, instr_valid_o=0; hold buffer cleared; imem_req_o=1 on the first cycle after reset.
- All outputs except imem_req_o/imem_addr_o are registered. Output registers update only when stall_i=0 or redirect_valid_i=1.
- Memory rule: once imem_req_o=1, the request and imem_addr_o stay asserted and stable until the cycle imem_ack_i=1.
- PC arithmetic: next PC = pc_q+2, wraps 16'hFFFE -> 16'h0000. redirect_pc_i[0] is forced to 0.
- FETCH state: req=1, addr=pc_q.
  - ack & !stall: outputs <= {pc_q, pc_q+2, rdata, valid=1}; pc_q += 2; stay in FETCH. Zero-wait memory gives 1 instruction/cycle, with 1-cycle latency from ack to outputs.
  - !ack & !stall: outputs <= {NOP_INSTR, valid=0}; pc_o/pc_plus2_o hold.
  - ack & stall: word goes to hold buffer {pc, pc+2, rdata}; pc_q += 2; go to HOLD. Outputs hold.
  - !ack & stall: outputs hold; stay in FETCH.
- HOLD state: req=0.
  - stall=1: stay in HOLD.
  - stall=0: outputs <= hold buffer (valid=1); go to FETCH.
- DROP state: req=1, addr=drop_addr, which is latched when entering DROP. No outputs valid.
  - ack: discard rdata; go to FETCH at pc_q.
  - no ack: stay in DROP.
- Redirect (highest priority, overrides stall): pc_q <= target; outputs <= {NOP_INSTR, valid=0} (flush).
  - FETCH & ack same cycle: discard rdata; go to FETCH.
  - FETCH & !ack: drop_addr <= pc_q; go to DROP.
  - HOLD: discard buffer; go to FETCH.
  - DROP: update pc_q only; stay in DROP, with drop_addr unchanged.
- Redirect followed by a new redirect before ack: the last target wins.
- Reset mid-request: FSM and outputs return to reset values immediately. The memory must tolerate a dropped request on reset.

Decomposition:
- Package if_pkg:
  - PC_W=16 and INSTR_W=16
  - typedef enum fetch_state_t {FETCH, HOLD, DROP}
  - typedef struct fetch_word_t {pc, pc_plus2, instr}, used for both the output and hold registers
  - NOP default constant
- No sub-module is needed. The FSM, PC register and hold buffer live in one module.

Test Plan:
- Reset, zero-wait memory (ack tied to req), RESET_PC=0 -> imem_addr 0,2,4 on consecutive cycles; outputs {0,2,I0,v=1}, then {2,4,I1,v=1}, one cycle after each ack.
- Memory with 2 wait states -> req/addr=0 stable 3 cycles; instr_valid_o=0 with NOP_INSTR during the wait; a single valid word follows; next addr is 2.
- Stall asserted the cycle ack arrives for addr 4 -> outputs hold the previous word; req=0 while stalled; after stall drops, outputs={4,6,I2,v=1} and the next request is addr 6.
- Redirect to 16'h0101 while the addr 8 request is pending (no ack) -> addr 8 held until ack; that data is discarded; valid stays 0; next request is addr 16'h0100.
- Redirect during HOLD with stall=1 -> outputs flush to NOP/valid=0 the same edge; buffered word is never delivered; next request is the target.
- RESET_PC=16'hFFFE -> first word has pc_plus2_o=16'h0000; second request addr=16'h0000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrop
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus2;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

  // Instruction addresses are halfword aligned.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ack to instruction memory and
// feeds {pc, pc+2, instr, valid} to IF/ID, honouring stalls and redirects.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus2_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o
);

  localparam fetch_word_t ResetWord = '{pc: '0, pc_plus2: '0, instr: NOP_INSTR};

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drop_addr_q, drop_addr_d;
  fetch_word_t     out_q, out_d;
  fetch_word_t     hold_q, hold_d;
  logic            valid_q, valid_d;
  fetch_word_t     fetched;

  assign fetched = '{pc: pc_q, pc_plus2: pc_inc(pc_q), instr: imem_rdata_i};

  // Request is a pure function of state so it stays stable until ack.
  assign imem_req_o  = (state_q != StHold);
  assign imem_addr_o = (state_q == StDrop) ? drop_addr_q : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    out_d       = out_q;
    hold_d      = hold_q;
    valid_d     = valid_q;

    if (redirect_valid_i) begin
      pc_d        = pc_align(redirect_pc_i);
      out_d.instr = NOP_INSTR;
      valid_d     = 1'b0;
      unique case (state_q)
        StFetch: begin
          if (imem_ack_i) begin
            state_d = StFetch;
          end else begin
            // The pending request must still complete; remember its address.
            drop_addr_d = pc_q;
            state_d     = StDrop;
          end
        end
        StHold:  state_d = StFetch;
        StDrop:  state_d = StDrop;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack_i) begin
            pc_d = pc_inc(pc_q);
            if (stall_i) begin
              hold_d  = fetched;
              state_d = StHold;
            end else begin
              out_d   = fetched;
              valid_d = 1'b1;
            end
          end else if (!stall_i) begin
            out_d.instr = NOP_INSTR;
            valid_d     = 1'b0;
          end
        end
        StHold: begin
          if (!stall_i) begin
            out_d   = hold_q;
            valid_d = 1'b1;
            state_d = StFetch;
          end
        end
        StDrop: begin
          if (!stall_i) begin
            out_d.instr = NOP_INSTR;
            valid_d     = 1'b0;
          end
          if (imem_ack_i) begin
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= pc_align(RESET_PC);
      drop_addr_q <= '0;
      out_q       <= ResetWord;
      hold_q      <= ResetWord;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      out_q       <= out_d;
      hold_q      <= hold_d;
      valid_q     <= valid_d;
    end
  end

  assign pc_o          = out_q.pc;
  assign pc_plus2_o    = out_q.pc_plus2;
  assign instr_o       = out_q.instr;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a cycle table for the main flow plus
// hand-written sequences for reset mid-request and PC wrap-around.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir;
  logic [15:0] redir_pc;
  logic        ack;
  logic [15:0] rdata;

  logic        req0, valid0, req1, valid1;
  logic [15:0] addr0, pc0, pc2_0, instr0;
  logic [15:0] addr1, pc1, pc2_1, instr1;

  int checks;
  int errors;

  if_fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0000)
  ) dut0 (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .redirect_valid_i(redir),
    .redirect_pc_i   (redir_pc),
    .imem_req_o      (req0),
    .imem_addr_o     (addr0),
    .imem_ack_i      (ack),
    .imem_rdata_i    (rdata),
    .pc_o            (pc0),
    .pc_plus2_o      (pc2_0),
    .instr_o         (instr0),
    .instr_valid_o   (valid0)
  );

  if_fetch_unit #(
    .RESET_PC (16'hFFFE),
    .NOP_INSTR(16'h0013)
  ) dut1 (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .redirect_valid_i(redir),
    .redirect_pc_i   (redir_pc),
    .imem_req_o      (req1),
    .imem_addr_o     (addr1),
    .imem_ack_i      (ack),
    .imem_rdata_i    (rdata),
    .pc_o            (pc1),
    .pc_plus2_o      (pc2_1),
    .instr_o         (instr1),
    .instr_valid_o   (valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] instr;
    logic        valid;
  } vec_t;

  localparam int NumVecs = 23;
  vec_t vecs[NumVecs];

  function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rpc,
                              input logic ak, input logic [15:0] rdat, input logic rq,
                              input logic [15:0] ad, input logic [15:0] p,
                              input logic [15:0] p2, input logic [15:0] ins, input logic v);
    vec_t r;
    r.stall = st;  r.redir = rd;  r.rpc = rpc;  r.ack = ak;  r.rdata = rdat;
    r.req = rq;    r.addr = ad;   r.pc = p;     r.pc2 = p2;  r.instr = ins;
    r.valid = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //              st rd rpc       ak rdata     rq addr      pc        pc2       instr     v
    vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 16'h0000, 16'h0002, 16'h1111, 1);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0002, 16'h0002, 16'h0004, 16'h2222, 1);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h0002, 16'h0004, 16'h0000, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h0002, 16'h0004, 16'h0000, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0004, 16'h0004, 16'h0006, 16'h3333, 1);
    vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'h0004, 16'h0006, 16'h3333, 1);
    vecs[6]  = mk(1, 0, 16'h0000, 1, 16'h4444, 1, 16'h0006, 16'h0004, 16'h0006, 16'h3333, 1);
    vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h0006, 16'h3333, 1);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0006, 16'h0008, 16'h4444, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0006, 16'h0008, 16'h0000, 0);
    vecs[10] = mk(0, 1, 16'h0101, 0, 16'h0000, 1, 16'h0008, 16'h0006, 16'h0008, 16'h0000, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0006, 16'h0008, 16'h0000, 0);
    vecs[12] = mk(0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0008, 16'h0006, 16'h0008, 16'h0000, 0);
    vecs[13] = mk(0, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h0008, 16'h0006, 16'h0008, 16'h0000, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0200, 16'h0200, 16'h0202, 16'h5555, 1);
    vecs[15] = mk(1, 0, 16'h0000, 1, 16'h6666, 1, 16'h0202, 16'h0200, 16'h0202, 16'h5555, 1);
    vecs[16] = mk(1, 1, 16'h0301, 0, 16'h0000, 0, 16'h0000, 16'h0200, 16'h0202, 16'h0000, 0);
    vecs[17] = mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0300, 16'h0300, 16'h0302, 16'h7777, 1);
    vecs[18] = mk(0, 1, 16'h0400, 1, 16'hBAD0, 1, 16'h0302, 16'h0300, 16'h0302, 16'h0000, 0);
    vecs[19] = mk(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0400, 16'h0400, 16'h0402, 16'h8888, 1);
    vecs[20] = mk(1, 1, 16'h0500, 0, 16'h0000, 1, 16'h0402, 16'h0400, 16'h0402, 16'h0000, 0);
    vecs[21] = mk(1, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0402, 16'h0400, 16'h0402, 16'h0000, 0);
    vecs[22] = mk(0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0500, 16'h0500, 16'h0502, 16'h9999, 1);

    reset = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = '0; ack = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);

    check("reset req", 16'(req0), 16'h0001);
    check("reset addr", addr0, 16'h0000);
    check("reset pc", pc0, 16'h0000);
    check("reset pc2", pc2_0, 16'h0000);
    check("reset instr", instr0, 16'h0000);
    check("reset valid", 16'(valid0), 16'h0000);

    reset = 1'b0;
    for (int i = 0; i < NumVecs; i++) begin
      stall = vecs[i].stall;  redir = vecs[i].redir;  redir_pc = vecs[i].rpc;
      ack = vecs[i].ack;      rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d req", i), 16'(req0), 16'(vecs[i].req));
      if (vecs[i].req) check($sformatf("v%0d addr", i), addr0, vecs[i].addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i), pc0, vecs[i].pc);
      check($sformatf("v%0d pc2", i), pc2_0, vecs[i].pc2);
      check($sformatf("v%0d instr", i), instr0, vecs[i].instr);
      check($sformatf("v%0d valid", i), 16'(valid0), 16'(vecs[i].valid));
      @(negedge clk);
    end

    // Reset asserted mid-cycle while a request is pending.
    stall = 1'b0; redir = 1'b0; ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst req", 16'(req0), 16'h0001);
    check("midrst addr", addr0, 16'h0000);
    check("midrst pc", pc0, 16'h0000);
    check("midrst instr", instr0, 16'h0000);
    check("midrst valid", 16'(valid0), 16'h0000);
    check("wrap rst addr", addr1, 16'hFFFE);
    check("wrap rst instr", instr1, 16'h0013);
    check("wrap rst valid", 16'(valid1), 16'h0000);

    // PC wrap-around on the RESET_PC=FFFE instance.
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; rdata = 16'hA1A1;
    #1;
    check("wrap req", 16'(req1), 16'h0001);
    check("wrap addr0", addr1, 16'hFFFE);
    @(posedge clk);
    #1;
    check("wrap pc", pc1, 16'hFFFE);
    check("wrap pc2", pc2_1, 16'h0000);
    check("wrap instr", instr1, 16'hA1A1);
    check("wrap valid", 16'(valid1), 16'h0001);
    @(negedge clk);
    rdata = 16'hB2B2;
    #1;
    check("wrap addr1", addr1, 16'h0000);
    @(posedge clk);
    #1;
    check("wrap pc b", pc1, 16'h0000);
    check("wrap pc2 b", pc2_1, 16'h0002);
    check("wrap instr b", instr1, 16'hB2B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
